// File: rtl/alu_hilo_sched.sv
// Issue-side sequencer for the multi-cycle HI/LO multiply/divide unit: starts the unit,
// counts its latency, pulses the HI/LO commit and stalls EX on HI/LO hazards.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// ST_IDLE   | nothing in flight; every HI/LO-class instruction is accepted
// ST_BUSY   | mul/div in flight; remaining_q counts down to the commit cycle
// ST_COMMIT | HI/LO captures the unit result at the end of this cycle
module alu_hilo_sched #(
    parameter int MUL_DELAY = 2,
    parameter int DIV_DELAY = 4,
    parameter int CNT_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             issue_valid_i,
    input  logic [2:0]       issue_op_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             start_o,
    output logic             start_div_o,
    output logic             move_we_o,
    output logic             commit_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] remaining_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MFHI = 3'd3;
    localparam logic [2:0] OP_MFLO = 3'd4;
    localparam logic [2:0] OP_MTHI = 3'd5;
    localparam logic [2:0] OP_MTLO = 3'd6;

    // The unit is started in the accept cycle and commits DELAY cycles later,
    // so the BUSY countdown spans DELAY-1 cycles ending at zero.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_DELAY - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_DELAY - 2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             op_div_q, op_div_d;

    logic is_long, is_read, is_write, is_hilo;
    logic hazard;
    logic accept;

    always_comb begin
        is_long  = (issue_op_i == OP_MUL)  || (issue_op_i == OP_DIV);
        is_read  = (issue_op_i == OP_MFHI) || (issue_op_i == OP_MFLO);
        is_write = (issue_op_i == OP_MTHI) || (issue_op_i == OP_MTLO);
        is_hilo  = is_long || is_read || is_write;
    end

    // In COMMIT a new long may issue back-to-back; reads and writes must wait
    // until the committed value is visible.
    always_comb begin
        hazard = 1'b0;
        case (state_q)
            ST_BUSY:   hazard = is_hilo;
            ST_COMMIT: hazard = is_read || is_write;
            default:   hazard = 1'b0;
        endcase
    end

    // Gating with rst_n_i keeps all combinational outputs low while reset is held.
    always_comb begin
        stall_o     = rst_n_i && issue_valid_i && !flush_i && hazard;
        accept      = rst_n_i && issue_valid_i && !flush_i && is_hilo && !hazard;
        start_o     = accept && is_long;
        start_div_o = start_o && (issue_op_i == OP_DIV);
        move_we_o   = accept && is_write;
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        op_div_d    = op_div_q;

        case (state_q)
            ST_IDLE: begin
                if (start_o) begin
                    state_d     = ST_BUSY;
                    remaining_d = start_div_o ? DIV_LOAD : MUL_LOAD;
                    op_div_d    = start_div_o;
                end
            end
            ST_BUSY: begin
                if (remaining_q != '0) begin
                    remaining_d = remaining_q - 1'b1;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (start_o) begin
                    state_d     = ST_BUSY;
                    remaining_d = start_div_o ? DIV_LOAD : MUL_LOAD;
                    op_div_d    = start_div_o;
                end else begin
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                remaining_d = '0;
            end
        endcase

        // A flush cancels anything in flight; a commit already in progress
        // still pulses this cycle because it is decoded from state_q.
        if (flush_i) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            op_div_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            op_div_q    <= op_div_d;
        end
    end

    always_comb begin
        commit_o    = (state_q == ST_COMMIT);
        busy_o      = (state_q != ST_IDLE);
        remaining_o = remaining_q;
    end

endmodule

// File: tb/tb_alu_hilo_sched.sv
// Bench for alu_hilo_sched: directed vector table for the latency/hazard/flush corners,
// then random traffic checked against a commit-cycle model of the sequencer.
module tb_alu_hilo_sched;

    localparam int MUL_DELAY = 2;
    localparam int DIV_DELAY = 4;
    localparam int CNT_W     = 4;

    logic             clk;
    logic             rst_n;
    logic             issue_valid;
    logic [2:0]       issue_op;
    logic             flush;
    logic             stall, start, start_div, move_we, commit, busy;
    logic [CNT_W-1:0] remaining;

    alu_hilo_sched #(
        .MUL_DELAY(MUL_DELAY),
        .DIV_DELAY(DIV_DELAY),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .issue_valid_i(issue_valid),
        .issue_op_i   (issue_op),
        .flush_i      (flush),
        .stall_o      (stall),
        .start_o      (start),
        .start_div_o  (start_div),
        .move_we_o    (move_we),
        .commit_o     (commit),
        .busy_o       (busy),
        .remaining_o  (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic [2:0] op;
        logic       f;
        logic       stall;
        logic       start;
        logic       sdiv;
        logic       mwe;
        logic       commit;
        logic       busy;
        int         rem;
    } vec_t;

    vec_t vecs[$];

    // Model: an in-flight long op is represented only by the cycle number it commits in.
    int t      = 0;
    int c_pend = -1;

    int e_stall, e_start, e_sdiv, e_mwe, e_commit, e_busy, e_rem;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, t, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [2:0] op, input logic f,
                                input logic st, input logic sa, input logic sd,
                                input logic mw, input logic cm, input logic bz, input int rm);
        vec_t r;
        r.v = v; r.op = op; r.f = f;
        r.stall = st; r.start = sa; r.sdiv = sd; r.mwe = mw;
        r.commit = cm; r.busy = bz; r.rem = rm;
        return r;
    endfunction

    task automatic model_eval();
        bit is_long, is_rd, is_wr, in_busy, in_commit, acc;
        is_long   = (issue_op == 3'd1) || (issue_op == 3'd2);
        is_rd     = (issue_op == 3'd3) || (issue_op == 3'd4);
        is_wr     = (issue_op == 3'd5) || (issue_op == 3'd6);
        in_busy   = (c_pend >= 0) && (t < c_pend);
        in_commit = (c_pend >= 0) && (t == c_pend);
        if (!rst_n) begin
            e_stall = 0; e_start = 0; e_sdiv = 0; e_mwe = 0;
            e_commit = 0; e_busy = 0; e_rem = 0;
        end else begin
            e_stall  = (issue_valid && !flush && (is_long || is_rd || is_wr) &&
                        (in_busy || (in_commit && !is_long))) ? 1 : 0;
            acc      = issue_valid && !flush && (is_long || is_rd || is_wr) && (e_stall == 0);
            e_start  = (acc && is_long) ? 1 : 0;
            e_sdiv   = (acc && issue_op == 3'd2) ? 1 : 0;
            e_mwe    = (acc && is_wr) ? 1 : 0;
            e_commit = in_commit ? 1 : 0;
            e_busy   = (in_busy || in_commit) ? 1 : 0;
            e_rem    = in_busy ? (c_pend - 1 - t) : 0;
        end
    endtask

    // Called after model_eval with the inputs that will be sampled at the next edge.
    task automatic model_advance();
        if (!rst_n) begin
            c_pend = -1;
        end else if (flush) begin
            if (c_pend >= 0 && t < c_pend) c_pend = -1;
        end else if (e_start != 0) begin
            c_pend = t + ((issue_op == 3'd2) ? DIV_DELAY : MUL_DELAY);
        end
        t++;
    endtask

    task automatic check_outputs(input int xs, input int xa, input int xd, input int xm,
                                 input int xc, input int xb, input int xr);
        chk("stall",     int'(stall),     xs);
        chk("start",     int'(start),     xa);
        chk("start_div", int'(start_div), xd);
        chk("move_we",   int'(move_we),   xm);
        chk("commit",    int'(commit),    xc);
        chk("busy",      int'(busy),      xb);
        chk("remaining", int'(remaining), xr);
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] op, input logic f);
        @(negedge clk);
        rst_n       = r;
        issue_valid = v;
        issue_op    = op;
        flush       = f;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; issue_valid = 1'b0; issue_op = 3'd0; flush = 1'b0;

        // Directed table, applied one vector per cycle from idle.
        //         v  op  f  stall start sdiv mwe commit busy rem
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0)); // mul accepted
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0)); // mul commit
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 0, 0, 1, 1, 0, 0, 0, 0)); // div accepted
        vecs.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, 1, 2)); // mflo held
        vecs.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 4, 0, 1, 0, 0, 0, 1, 1, 0)); // read stalled in COMMIT
        vecs.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 0)); // mflo accepted
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0)); // mul
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 0)); // second mul stalled
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 1, 0)); // back-to-back in COMMIT
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0)); // second commit
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 0, 0, 1, 1, 0, 0, 0, 0)); // div
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1)); // flush in BUSY
        vecs.push_back(mk(1, 5, 0, 0, 0, 0, 1, 0, 0, 0)); // mthi after flush
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // cancelled div never commits
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0)); // mul
        vecs.push_back(mk(1, 6, 0, 1, 0, 0, 0, 0, 1, 0)); // mtlo stalled in BUSY
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0)); // flush in COMMIT keeps commit
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0)); // flush beats mthi
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0)); // flush beats mul
        vecs.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 0, 0)); // reserved op
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // none op
        vecs.push_back(mk(1, 2, 0, 0, 1, 1, 0, 0, 0, 0)); // div
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 1, 0)); // flush+mul in COMMIT
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset held while a mul is presented: nothing may come out.
        drive(1'b0, 1'b1, 3'd1, 1'b0);
        check_outputs(0, 0, 0, 0, 0, 0, 0);
        model_eval(); model_advance();
        drive(1'b0, 1'b1, 3'd1, 1'b0);
        check_outputs(0, 0, 0, 0, 0, 0, 0);
        model_eval(); model_advance();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 3'd0, 1'b0);
            check_outputs(0, 0, 0, 0, 0, 0, 0);
            model_eval(); model_advance();
        end

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].v, vecs[i].op, vecs[i].f);
            check_outputs(vecs[i].stall, vecs[i].start, vecs[i].sdiv, vecs[i].mwe,
                          vecs[i].commit, vecs[i].busy, vecs[i].rem);
            model_eval(); model_advance();
        end

        // Reset asserted mid-divide: discarded, no commit afterwards.
        drive(1'b1, 1'b1, 3'd2, 1'b0);
        chk("rst_mid_start", int'(start), 1);
        model_eval(); model_advance();
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        check_outputs(0, 0, 0, 0, 0, 0, 0);
        model_eval(); model_advance();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 3'd0, 1'b0);
            chk("rst_mid_commit", int'(commit), 0);
            chk("rst_mid_busy", int'(busy), 0);
            model_eval(); model_advance();
        end

        // Random traffic against the commit-cycle model.
        for (int i = 0; i < 3000; i++) begin
            logic       r, v, f;
            logic [2:0] op;
            r  = ($urandom_range(0, 199) != 0);
            v  = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            f  = ($urandom_range(0, 15) == 0);
            drive(r, v, op, f);
            model_eval();
            check_outputs(e_stall, e_start, e_sdiv, e_mwe, e_commit, e_busy, e_rem);
            model_advance();
        end

        drive(1'b1, 1'b0, 3'd0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_hilo_sched.md
Name: alu_hilo_sched

Overview:
- Issue-side sequencer for the multi-cycle HI/LO ALU unit.
- Accepts multiply/divide and HI/LO move requests from the execute stage.
- Starts the unit and counts its latency, then pulses the HI/LO commit.
- Stalls the pipeline on any HI/LO structural or data hazard while an operation is in flight; one instance sits beside the ALU in the EX stage.

Parameters:
- MUL_DELAY, 2: cycles from multiply accept to its commit cycle; must be >= 2.
- DIV_DELAY, 4: cycles from divide accept to its commit cycle; must be >= 2.
- CNT_W, 4: counter width; must satisfy 2^CNT_W > max(MUL_DELAY, DIV_DELAY).

Ports:
- clock, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low reset. Reset is asserted when the signal is 0.
- issue_valid, in, 1: EX stage presents a HI/LO-class instruction this cycle.
- issue_op, in, 3: 0 none, 1 mul, 2 div, 3 mfhi, 4 mflo, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- flush, in, 1: pipeline flush; cancels any in-flight operation.
- stall, out, 1: combinational; hold the EX stage, instruction not accepted.
- start, out, 1: combinational; one-cycle pulse when mul/div is accepted.
- start_div, out, 1: qualifies start; 1 = divide, 0 = multiply.
- move_we, out, 1: combinational; accepted mthi/mtlo write strobe this cycle.
- commit, out, 1: registered; one-cycle pulse; HI/LO captures the unit result at the end of this cycle.
- busy, out, 1: registered; state is not IDLE.
- remaining, out, CNT_W: registered; current countdown value, 0 outside BUSY.

Behaviour:
- States: IDLE, BUSY, COMMIT. A 1-bit op_div register records the in-flight operation type.
- Reset (reset=0, asynchronous): state=IDLE, remaining=0, op_div=0. Combinational outputs then evaluate to 0 (stall=0, start=0, start_div=0, move_we=0, commit=0, busy=0).
- Reset mid-operation: the in-flight operation is discarded with no commit pulse.
- Hazard classes:
  - mul/div = "long".
  - mfhi/mflo = "read".
  - mthi/mtlo = "write".
  - none/reserved never stall, never accept.
- Stall rules (issue_valid=1 and flush=0):
  - IDLE: never stall.
  - BUSY: stall on long, read and write.
  - COMMIT: stall on read (the HI/LO value is not yet visible) and on write (it would race the commit). Do not stall on long: back-to-back issue is allowed.
- Accept = issue_valid & class is long/read/write & !stall & !flush.
- Accepted long:
  - start=1 and start_div=(op==div) in the same cycle.
  - Next state BUSY, remaining loaded with DELAY-2 (DELAY per op), op_div latched.
- Accepted write: move_we=1 that cycle; state unchanged (IDLE stays IDLE).
- Accepted read: no output action; the datapath reads HI/LO directly.
- BUSY:
  - If remaining != 0, decrement.
  - If remaining == 0, next state COMMIT.
- COMMIT:
  - commit=1 for exactly this cycle.
  - Next state IDLE, or BUSY if a new long is accepted in the same cycle.
- Latency: a long accepted in cycle T gives commit=1 in cycle T+DELAY. The first read is accepted no earlier than T+DELAY+1.
- Flush:
  - Forces next state IDLE and remaining=0.
  - Suppresses accept, start and move_we that cycle; stall=0 that cycle.
  - Flush in COMMIT: the commit pulse of that cycle still occurs (the result is architecturally older than the flushed instructions).
  - Flush in BUSY: no commit pulse for the cancelled operation.
- Simultaneous flush + issue: the flush wins and nothing is accepted.
- No wrap-around: the counter never decrements below 0.

Test Plan:
- Reset low while issuing mul -> all outputs 0; after release with idle inputs they stay 0.
- MUL_DELAY=2: mul accepted at cycle 5 -> start=1, start_div=0 at 5; busy=1 at 6 with remaining=0; commit=1 at 7; busy=0 at 8.
- DIV_DELAY=4: div at cycle 10, then mflo held valid -> start_div=1 at 10; remaining 2,1,0 at 11-13; commit at 14; stall=1 cycles 11-14; mflo accepted at 15.
- mul at 20, then mul held valid from 21 -> second mul stalled at 21, accepted at 22 (COMMIT) with start=1; second commit at 24.
- div at 30, flush at 32 -> no commit pulse; busy=0 at 33; a mthi at 33 gives move_we=1 at 33.
- mul at 40, flush in its COMMIT cycle 42 -> commit=1 at 42; IDLE at 43; mtlo during cycle 41 stalled, move_we=0.
